// File: rtl/arith_pipe_if.sv
// arith_pipe_if: operand/result valid-ready bundle for arith_pipe
interface arith_pipe_if #(parameter int WIDTH = 8);
    logic             in_valid, in_ready, s, out_valid, out_ready, flag;
    logic [WIDTH-1:0] a, b, c, out;
    modport master (output in_valid, a, b, c, s, out_ready, input in_ready, out_valid, out, flag);
    modport slave (input in_valid, a, b, c, s, out_ready, output in_ready, out_valid, out, flag);
endinterface

// File: rtl/arith_pipe.sv
// arith_pipe: two-stage add/subtract pipeline with valid-ready flow control, optional clamping.
// Define ARITH_PIPE_MONITOR_EN to add the sum/difference/transfer-count monitor ports.
module arith_pipe #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input logic        clk,
    input logic        reset,
    arith_pipe_if.slave io
`ifdef ARITH_PIPE_MONITOR_EN
    ,
    output logic [WIDTH-1:0] add_sum_monitor,
    output logic [WIDTH-1:0] sub_diff_monitor,
    output logic [15:0]      op_count_monitor
`endif
);
    logic             s1_valid, s1_s, s1_adv, s2_adv, res_flag;
    logic [WIDTH-1:0] s1_a, s1_b, s1_c, res;
    logic [WIDTH:0]   sum, diff;
    assign s2_adv      = !io.out_valid || io.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign io.in_ready = s1_adv;
    // zero-extended operands: top bit of the sum is carry, of the difference is borrow
    assign sum      = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff     = {1'b0, s1_a} - {1'b0, s1_c};
    assign res_flag = s1_s ? diff[WIDTH] : sum[WIDTH];
    assign res      = (SATURATE != 0 && res_flag) ? (s1_s ? '0 : '1)
                    : (s1_s ? diff[WIDTH-1:0] : sum[WIDTH-1:0]);
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            io.out_valid <= 1'b0;
            io.out       <= '0;
            io.flag      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= io.in_valid;
                if (io.in_valid) begin
                    s1_a <= io.a;
                    s1_b <= io.b;
                    s1_c <= io.c;
                    s1_s <= io.s;
                end
            end
            if (s2_adv) begin
                io.out_valid <= s1_valid;
                if (s1_valid) begin
                    io.out  <= res;
                    io.flag <= res_flag;
                end
            end
        end
    end
`ifdef ARITH_PIPE_MONITOR_EN
    assign add_sum_monitor  = sum[WIDTH-1:0];
    assign sub_diff_monitor = diff[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (reset) op_count_monitor <= '0;
        else if (io.out_valid && io.out_ready) op_count_monitor <= op_count_monitor + 16'd1;
    end
`endif
endmodule
